// File: rtl/ob_lm_table_cnt_acc.sv
// ob_lm_table_cnt_acc: folds per-beat carry-save pairs into a running
// carry-save accumulator with a 4:2 compressor. On the last beat it resolves
// the total with a segmented CPA, CPA_W bits per cycle. The result is returned
// on a valid/ready output.
// Optional feature: define OB_LM_TABLE_CNT_ACC_BEATS_EN to add the out_beats
// port, which reports the number of beats accepted in the packet.
module ob_lm_table_cnt_acc #(
    parameter int W     = 32,
    parameter int CPA_W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    input  logic         in_last,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_sum
`ifdef OB_LM_TABLE_CNT_ACC_BEATS_EN
    ,
    output logic [15:0]  out_beats
`endif
);

    localparam int NSEG  = W / CPA_W;
    localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

    typedef enum logic [1:0] {S_ACC, S_RESOLVE, S_OUT} state_t;

    state_t             state;
    logic [W-1:0]       acc_s, acc_c;
    logic [W-1:0]       res;
    logic [SEG_W-1:0]   seg;
    logic               cy;
    logic [W-1:0]       t_s, t_c, n_s, n_c;
    logic [CPA_W:0]     seg_sum;
`ifdef OB_LM_TABLE_CNT_ACC_BEATS_EN
    logic [15:0]        beats;
    assign out_beats = beats;
`endif

    assign in_rdy  = (state == S_ACC);
    assign out_vld = (state == S_OUT);
    assign out_sum = res;

    // 4:2 compression as two 3:2 stages; shifted carries drop the MSB (mod 2^W)
    always_comb begin
        t_s = acc_s ^ acc_c ^ in_s;
        t_c = ((acc_s & acc_c) | (acc_s & in_s) | (acc_c & in_s)) << 1;
        n_s = t_s ^ t_c ^ in_c;
        n_c = ((t_s & t_c) | (t_s & in_c) | (t_c & in_c)) << 1;
    end

    // One CPA segment: current slice of both words plus the carry from below
    assign seg_sum = {1'b0, acc_s[seg*CPA_W +: CPA_W]}
                   + {1'b0, acc_c[seg*CPA_W +: CPA_W]}
                   + (CPA_W+1)'(cy);

    // Control FSM: accumulate, resolve segment by segment, then hold the result
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_ACC;
            acc_s <= '0;
            acc_c <= '0;
            seg   <= '0;
            cy    <= 1'b0;
            res   <= '0;
`ifdef OB_LM_TABLE_CNT_ACC_BEATS_EN
            beats <= '0;
`endif
        end else begin
            case (state)
                S_ACC: begin
                    if (in_vld) begin
                        acc_s <= n_s;
                        acc_c <= n_c;
`ifdef OB_LM_TABLE_CNT_ACC_BEATS_EN
                        if (beats != 16'hFFFF) beats <= beats + 16'd1;
`endif
                        if (in_last) begin
                            state <= S_RESOLVE;
                            seg   <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                S_RESOLVE: begin
                    res[seg*CPA_W +: CPA_W] <= seg_sum[CPA_W-1:0];
                    cy  <= seg_sum[CPA_W];
                    seg <= seg + 1'b1;
                    // carry out of the MSB segment is dropped (mod 2^W)
                    if (seg == LAST_SEG) state <= S_OUT;
                end
                S_OUT: begin
                    if (out_rdy) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        state <= S_ACC;
`ifdef OB_LM_TABLE_CNT_ACC_BEATS_EN
                        beats <= '0;
`endif
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule
